// File: rtl/tg_mux_seq_pkg.sv
// Shared types and constants for the transmission-gate mux sequencer.
package tg_mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWITCH  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Largest legal settle time; sizes the settle counter.
    localparam int SETTLE_MAX = 32'd15;

    // Number of bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 32'd1;
        while ((32'd1 << w) <= max_val) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

    localparam int CNT_W = cnt_width(SETTLE_MAX);

endpackage

// File: rtl/tg_mux_seq_slot.sv
// One-entry holding slot for a valid/ready input stream. The stored word is
// frozen while full so the mux data pin stays stable through settle/present.
module tg_mux_seq_slot
    import tg_mux_seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] q
);

    logic             full_r;
    logic [WIDTH-1:0] data_r;
    logic             load_s;

    assign load_s = valid & ~full_r;
    assign ready  = ~full_r;
    assign full   = full_r;
    assign q      = data_r;

    // Slot register and full flag: load when empty and offered, clear on grant handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            full_r <= 1'b1;
            data_r <= data;
        end else if (clear) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

endmodule

// File: rtl/tg_mux2_sequencer.sv
// Sequencer in front of a 2:1 transmission-gate mux: buffers two streams,
// arbitrates round-robin, drives A/B/S and flags Y valid only after S settles.
module tg_mux2_sequencer
    import tg_mux_seq_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    output logic             mux_s,
    output logic             out_valid,
    output logic             out_src,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mux_s_r;
    logic             last_src_r;
    logic             out_valid_r;
    logic             out_src_r;

    logic             a_full_s;
    logic             b_full_s;
    logic             any_full_s;
    logic             cand_s;
    logic             out_fire_s;
    logic             a_clr_s;
    logic             b_clr_s;

    assign out_fire_s = out_valid_r & out_ready;
    assign a_clr_s    = out_fire_s & (mux_s_r == SRC_A);
    assign b_clr_s    = out_fire_s & (mux_s_r == SRC_B);
    assign any_full_s = a_full_s | b_full_s;

    tg_mux_seq_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk   (clk),
        .rst   (rst),
        .valid (a_valid),
        .data  (a_data),
        .clear (a_clr_s),
        .ready (a_ready),
        .full  (a_full_s),
        .q     (mux_a)
    );

    tg_mux_seq_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk   (clk),
        .rst   (rst),
        .valid (b_valid),
        .data  (b_data),
        .clear (b_clr_s),
        .ready (b_ready),
        .full  (b_full_s),
        .q     (mux_b)
    );

    // Candidate source: the only full slot, or the one not served last on a tie.
    always_comb begin
        if (a_full_s && b_full_s) begin
            cand_s = ~last_src_r;
        end else if (b_full_s) begin
            cand_s = SRC_B;
        end else begin
            cand_s = SRC_A;
        end
    end

    // Grant FSM with settle counter; S only moves on IDLE->SWITCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            mux_s_r     <= SRC_A;
            last_src_r  <= SRC_B;
            out_valid_r <= 1'b0;
            out_src_r   <= SRC_A;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_full_s) begin
                        if (cand_s == mux_s_r) begin
                            state_r     <= PRESENT;
                            out_valid_r <= 1'b1;
                            out_src_r   <= mux_s_r;
                        end else begin
                            state_r <= SWITCH;
                            mux_s_r <= cand_s;
                            cnt_r   <= SETTLE_M1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SWITCH: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r     <= PRESENT;
                        out_valid_r <= 1'b1;
                        out_src_r   <= mux_s_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        last_src_r  <= mux_s_r;
                    end else begin
                        state_r <= PRESENT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mux_s     = mux_s_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_tg_mux2_sequencer.sv
// Self-checking bench: directed vector table, hand sequences for hold/reset/
// alternation, and randomized traffic against a timestamp-based reference model.
module tb_tg_mux2_sequencer;

    localparam int W = 4;
    localparam int S = 3;

    logic         clk;
    logic         rst;
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic [W-1:0] mux_a;
    logic [W-1:0] mux_b;
    logic         mux_s;
    logic         out_valid;
    logic         out_src;
    logic         out_ready;

    tg_mux2_sequencer #(.WIDTH(W), .SETTLE_CYC(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .mux_a     (mux_a),
        .mux_b     (mux_b),
        .mux_s     (mux_s),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    // Reference model: slot contents plus "grant pending, valid from cycle N".
    bit [1:0]     m_full;
    logic [W-1:0] m_data [2];
    bit           m_sel;
    bit           m_last;
    bit           m_busy;
    int           m_valid_at;

    // Values observed at the last sample point
    logic         s_ar, s_br, s_ov, s_src, s_s;
    logic [W-1:0] s_ma, s_mb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    function automatic bit model_ov();
        return m_busy && (cyc >= m_valid_at);
    endfunction

    task automatic model_check();
        chk("m_a_ready", a_ready, !m_full[0]);
        chk("m_b_ready", b_ready, !m_full[1]);
        chk("m_out_valid", out_valid, model_ov());
        chk("m_mux_s", mux_s, m_sel);
        chk("m_mux_a", mux_a, m_data[0]);
        chk("m_mux_b", mux_b, m_data[1]);
        if (model_ov()) chk("m_out_src", out_src, m_sel);
    endtask

    task automatic model_step(input bit r, input bit av, input logic [W-1:0] ad,
                              input bit bv, input logic [W-1:0] bd, input bit ordy);
        bit [1:0] of;
        bit       cand;
        bit       ov;
        ov = model_ov();
        if (r) begin
            m_full = 2'b00; m_data[0] = '0; m_data[1] = '0;
            m_sel = 0; m_last = 1; m_busy = 0; m_valid_at = 0;
        end else begin
            of = m_full;
            if (!m_busy) begin
                if (of != 2'b00) begin
                    cand = (of == 2'b11) ? !m_last : of[1];
                    m_busy = 1;
                    if (cand == m_sel) m_valid_at = cyc + 1;
                    else begin
                        m_sel = cand;
                        m_valid_at = cyc + 1 + S;
                    end
                end
            end else if (ov && ordy) begin
                m_full[m_sel] = 0;
                m_last = m_sel;
                m_busy = 0;
            end
            if (av && !of[0]) begin m_full[0] = 1; m_data[0] = ad; end
            if (bv && !of[1]) begin m_full[1] = 1; m_data[1] = bd; end
        end
        cyc++;
    endtask

    task automatic cycle(input bit r, input bit av, input logic [W-1:0] ad,
                         input bit bv, input logic [W-1:0] bd, input bit ordy);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        @(negedge clk);
        if (chk_en) model_check();
        s_ar = a_ready; s_br = b_ready; s_ov = out_valid; s_src = out_src;
        s_s = mux_s; s_ma = mux_a; s_mb = mux_b;
        model_step(r, av, ad, bv, bd, ordy);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit r; bit av; logic [W-1:0] ad; bit bv; logic [W-1:0] bd; bit ordy;
        bit e_ar; bit e_br; bit e_ov; bit e_src; bit e_s;
        logic [W-1:0] e_ma; logic [W-1:0] e_mb;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit   have_prev;
        logic prev_src;
        int   grants;

        // Hand-derived vectors for SETTLE_CYC = 3.
        tbl[0]  = '{1,1,4'd5,1,4'd9,0, 1,1,0,0,0, 4'd0,4'd0};
        tbl[1]  = '{0,1,4'd5,1,4'd9,0, 1,1,0,0,0, 4'd0,4'd0};
        tbl[2]  = '{0,0,4'd0,0,4'd0,0, 0,0,0,0,0, 4'd5,4'd9};
        tbl[3]  = '{0,0,4'd0,0,4'd0,1, 0,0,1,0,0, 4'd5,4'd9};
        tbl[4]  = '{0,0,4'd0,0,4'd0,1, 1,0,0,0,0, 4'd5,4'd9};
        tbl[5]  = '{0,0,4'd0,0,4'd0,1, 1,0,0,0,1, 4'd5,4'd9};
        tbl[6]  = '{0,0,4'd0,0,4'd0,1, 1,0,0,0,1, 4'd5,4'd9};
        tbl[7]  = '{0,0,4'd0,0,4'd0,1, 1,0,0,0,1, 4'd5,4'd9};
        tbl[8]  = '{0,0,4'd0,0,4'd0,1, 1,0,1,1,1, 4'd5,4'd9};
        tbl[9]  = '{0,0,4'd0,1,4'd3,1, 1,1,0,0,1, 4'd5,4'd9};
        tbl[10] = '{0,0,4'd0,0,4'd0,1, 1,0,0,0,1, 4'd5,4'd3};
        tbl[11] = '{0,0,4'd0,0,4'd0,1, 1,0,1,1,1, 4'd5,4'd3};
        tbl[12] = '{0,1,4'd6,0,4'd0,0, 1,1,0,0,1, 4'd5,4'd3};
        tbl[13] = '{0,0,4'd0,0,4'd0,0, 0,1,0,0,1, 4'd6,4'd3};
        tbl[14] = '{0,0,4'd0,0,4'd0,0, 0,1,0,0,0, 4'd6,4'd3};
        tbl[15] = '{0,0,4'd0,0,4'd0,0, 0,1,0,0,0, 4'd6,4'd3};
        tbl[16] = '{0,0,4'd0,0,4'd0,0, 0,1,0,0,0, 4'd6,4'd3};
        tbl[17] = '{0,0,4'd0,0,4'd0,0, 0,1,1,0,0, 4'd6,4'd3};

        // Initial reset edge; outputs are undefined before it.
        cycle(1, 0, '0, 0, '0, 0);
        chk_en = 1;

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].r, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].ordy);
            chk($sformatf("t%0d_a_ready", i), s_ar, tbl[i].e_ar);
            chk($sformatf("t%0d_b_ready", i), s_br, tbl[i].e_br);
            chk($sformatf("t%0d_out_valid", i), s_ov, tbl[i].e_ov);
            chk($sformatf("t%0d_mux_s", i), s_s, tbl[i].e_s);
            chk($sformatf("t%0d_mux_a", i), s_ma, tbl[i].e_ma);
            chk($sformatf("t%0d_mux_b", i), s_mb, tbl[i].e_mb);
            if (tbl[i].e_ov) chk($sformatf("t%0d_out_src", i), s_src, tbl[i].e_src);
        end

        // Stall in PRESENT for 10 cycles while B keeps offering words.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, '0, 1, W'(i + 2), 0);
            chk("hold_out_valid", s_ov, 1'b1);
            chk("hold_out_src", s_src, 1'b0);
            chk("hold_mux_s", s_s, 1'b0);
            chk("hold_mux_a", s_ma, 4'd6);
            chk("hold_b_ready", s_br, (i == 0));
            chk("hold_mux_b", s_mb, (i == 0) ? 4'd3 : 4'd2);
        end
        cycle(0, 0, '0, 0, '0, 1);
        chk("hold_release", s_ov, 1'b1);
        cycle(0, 0, '0, 0, '0, 0);
        chk("idle_after_release", s_ov, 1'b0);
        // Now in SWITCH towards B; assert reset here.
        cycle(1, 0, '0, 0, '0, 0);
        chk("in_switch_mux_s", s_s, 1'b1);
        cycle(0, 0, '0, 0, '0, 0);
        chk("rst_sw_mux_s", s_s, 1'b0);
        chk("rst_sw_out_valid", s_ov, 1'b0);
        chk("rst_sw_a_ready", s_ar, 1'b1);
        chk("rst_sw_b_ready", s_br, 1'b1);
        chk("rst_sw_mux_b", s_mb, 4'd0);

        // Continuous refill on both channels: grants must alternate, A first.
        have_prev = 0; prev_src = 0; grants = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1, W'($urandom), 1, W'($urandom), 1);
            if (s_ov) begin
                if (!have_prev) chk("alt_first_grant", s_src, 1'b0);
                else            chk("alt_grant_order", s_src, !prev_src);
                have_prev = 1; prev_src = s_src; grants++;
            end
        end
        chk("alt_grant_count_min", (grants >= 10), 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(63) == 0), $urandom_range(1), W'($urandom),
                  $urandom_range(1), W'($urandom), ($urandom_range(9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
